// File: rtl/pfd_pkg.sv
// Shared types and count-instruction encodings for the ADPLL phase-frequency
// detector and the up/down counter that consumes its instructions.
package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REF_LEAD = 2'b01,
    FB_LEAD  = 2'b10
  } pfd_state_t;

  localparam logic [1:0] CI_HOLD = 2'b00;
  localparam logic [1:0] CI_UP   = 2'b01;
  localparam logic [1:0] CI_DOWN = 2'b10;

  function automatic logic [1:0] state_to_ci(input pfd_state_t state);
    case (state)
      REF_LEAD: return CI_UP;
      FB_LEAD:  return CI_DOWN;
      default:  return CI_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/edge_synchroniser.sv
// Brings one asynchronous clock into the fpga_clk domain and reports each
// rising edge as a single-cycle pulse, suppressed while enable_i is low.
module edge_synchroniser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fpga_clk_i,
  input  logic reset_i,
  input  logic async_i,
  input  logic enable_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its predecessor's value from before this clock edge.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // The previous-sample flop keeps tracking while disabled, so a level that
  // was already high when enable_i rises is not reported as a fresh edge.
  assign rise_o = enable_i & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/phase_frequency_detector.sv
// Digital PFD: decides which of ref/fb leads and drives up/down/hold plus
// window-close pulses. Define PFD_TIMEOUT_EN to compile in the lead-window timer.
module phase_frequency_detector
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic       fpga_clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       ref_clk_i,
  input  logic       fb_clk_i,
  output logic [1:0] count_instr_o,
  output logic       clear_o,
  output logic       timeout_o
);

  logic       ref_rise;
  logic       fb_rise;
  pfd_state_t state_q, state_d;
  logic       clear_q, clear_d;

  edge_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .async_i    (ref_clk_i),
    .enable_i   (enable_i),
    .rise_o     (ref_rise)
  );

  edge_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .async_i    (fb_clk_i),
    .enable_i   (enable_i),
    .rise_o     (fb_rise)
  );

`ifdef PFD_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = {TIMEOUT_WIDTH{1'b1}} - 1'b1;

  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     timeout_q, timeout_d;
  logic                     timer_expired;

  // The increment made in this cycle brings the timer to all-ones.
  assign timer_expired = (timer_q == TIMER_LAST);
`endif

  // NOTE: every output of this block gets a default before any branch so
  // that no path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
`ifdef PFD_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise && fb_rise) clear_d = 1'b1;
          else if (ref_rise)       state_d = REF_LEAD;
          else if (fb_rise)        state_d = FB_LEAD;
        end
        REF_LEAD: begin
          if (fb_rise) begin
            clear_d = 1'b1;
            state_d = ref_rise ? REF_LEAD : IDLE;
          end
        end
        FB_LEAD: begin
          if (ref_rise) begin
            clear_d = 1'b1;
            state_d = fb_rise ? FB_LEAD : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef PFD_TIMEOUT_EN
      // A closing edge always wins over expiry in the same cycle.
      if (state_q != IDLE && !clear_d && timer_expired) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
    end
  end

`ifdef PFD_TIMEOUT_EN
  // Restart on any window opening (including simultaneous-edge reopening).
  always_comb begin
    if (state_q == IDLE || state_d != state_q || clear_d) timer_d = '0;
    else                                                  timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  // TIMEOUT_WIDTH has no effect without the timer; the output is constant 0.
  assign timeout_o = 1'b0 & (TIMEOUT_WIDTH > 0);
`endif

  // Decoded straight from the state flop so reset clears it without a clock.
  assign count_instr_o = state_to_ci(state_q);
  assign clear_o       = clear_q;

endmodule

// File: tb/tb_phase_frequency_detector.sv
// Self-checking bench for phase_frequency_detector: directed windows plus
// randomized ref/fb waveforms compared against a cycle-indexed window model.
module tb_phase_frequency_detector;
  import pfd_pkg::*;

  localparam int SYNC      = 2;
  localparam int TW        = 4;
  localparam int TO_CYCLES = (1 << TW) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ref_in;
  logic       fb_in;
  logic [1:0] ci;
  logic       clr;
  logic       tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  phase_frequency_detector #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .fpga_clk_i    (clk),
    .reset_i       (rst_n),
    .enable_i      (en),
    .ref_clk_i     (ref_in),
    .fb_clk_i      (fb_in),
    .count_instr_o (ci),
    .clear_o       (clr),
    .timeout_o     (tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input samples indexed by age, and an open window
  // described by its direction and the clock cycle at which it opened.
  bit ref_h[SYNC+2];
  bit fb_h[SYNC+2];
  int m_dir;     // 0 none, 1 reference leads, 2 feedback leads
  int m_open;
  int m_cycle;
  bit m_clear;
  bit m_tmo;

  function automatic void model_reset();
    for (int i = 0; i < SYNC + 2; i++) begin
      ref_h[i] = 1'b0;
      fb_h[i]  = 1'b0;
    end
    m_dir   = 0;
    m_open  = 0;
    m_cycle = 0;
    m_clear = 1'b0;
    m_tmo   = 1'b0;
  endfunction

  function automatic void model_step();
    bit r, f, mine, other;
    m_cycle++;
    for (int i = SYNC + 1; i > 0; i--) begin
      ref_h[i] = ref_h[i-1];
      fb_h[i]  = fb_h[i-1];
    end
    ref_h[0] = ref_in;
    fb_h[0]  = fb_in;
    // An input rise is seen SYNC samples later, and only while enabled.
    r = en && ref_h[SYNC] && !ref_h[SYNC+1];
    f = en && fb_h[SYNC]  && !fb_h[SYNC+1];
    m_clear = 1'b0;
    m_tmo   = 1'b0;
    if (!en) begin
      m_dir = 0;
    end else if (m_dir == 0) begin
      if (r && f)  m_clear = 1'b1;
      else if (r) begin m_dir = 1; m_open = m_cycle; end
      else if (f) begin m_dir = 2; m_open = m_cycle; end
    end else begin
      mine  = (m_dir == 1) ? r : f;
      other = (m_dir == 1) ? f : r;
      if (other) begin
        m_clear = 1'b1;
        if (mine) m_open = m_cycle;
        else      m_dir  = 0;
      end
`ifdef PFD_TIMEOUT_EN
      else if (m_cycle - m_open >= TO_CYCLES) begin
        m_dir = 0;
        m_tmo = 1'b1;
      end
`endif
    end
  endfunction

  function automatic logic [1:0] model_ci();
    return (m_dir == 1) ? CI_UP : (m_dir == 2) ? CI_DOWN : CI_HOLD;
  endfunction

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic tick(input bit r, input bit f, input bit e);
    ref_in = r;
    fb_in  = f;
    en     = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("count_instr", ci,  model_ci());
    check("clear",       clr, m_clear);
    check("timeout",     tmo, m_tmo);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_count_instr", ci,  CI_HOLD);
    check("rst_clear",       clr, 1'b0);
    check("rst_timeout",     tmo, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ref_in = ~ref_in;
      fb_in  = 1'($urandom_range(0, 1));
      en     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_hold_ci",  ci,  CI_HOLD);
      check("rst_hold_clr", clr, 1'b0);
      check("rst_hold_tmo", tmo, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SYNC + 2; i++) tick(ref_in, fb_in, 1'b0);
    for (int i = 0; i < SYNC + 2; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    for (int i = 0; i < SYNC + 2; i++) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)        tick(1'b0, 1'b0, 1'b1);
  endtask

  // Leading input rises at index 0, the other at index gap (gap 0 = same cycle).
  task automatic run_window(input bit ref_first, input int gap, input int total,
                            output int lead, output int clears, output int tmos,
                            output int first_clear);
    bit r, f;
    lead = 0; clears = 0; tmos = 0; first_clear = -1;
    for (int i = 0; i < total; i++) begin
      r = ref_first ? 1'b1 : (i >= gap);
      f = ref_first ? (i >= gap) : 1'b1;
      tick(r, f, 1'b1);
      if (ci != CI_HOLD) lead++;
      if (clr) begin
        clears++;
        if (first_clear < 0) first_clear = i;
      end
      if (tmo) tmos++;
    end
  endtask

  initial begin
    int lead, clears, tmos, first_clear;
    int ref_cnt, fb_cnt, dis_cnt;
    bit r, f;

    rst_n  = 1'b0;
    en     = 1'b0;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    do_reset();
    settle();

    run_window(1'b1, 10, 10 + SYNC + 4, lead, clears, tmos, first_clear);
    check("ref_lead_len",    lead,        10);
    check("ref_lead_clears", clears,      1);
    check("ref_lead_clr_at", first_clear, 10 + SYNC);
    check("ref_lead_tmos",   tmos,        0);
    settle();

    run_window(1'b0, 5, 5 + SYNC + 4, lead, clears, tmos, first_clear);
    check("fb_lead_len",    lead,        5);
    check("fb_lead_clears", clears,      1);
    check("fb_lead_clr_at", first_clear, 5 + SYNC);
    settle();

    run_window(1'b1, 0, SYNC + 5, lead, clears, tmos, first_clear);
    check("simul_lead_len", lead,        0);
    check("simul_clears",   clears,      1);
    check("simul_clr_at",   first_clear, SYNC);
    settle();

`ifdef PFD_TIMEOUT_EN
    run_window(1'b1, 1000, 40, lead, clears, tmos, first_clear);
    check("timeout_lead_len", lead,   TO_CYCLES);
    check("timeout_pulses",   tmos,   1);
    check("timeout_clears",   clears, 0);
`else
    run_window(1'b1, 1000, 120, lead, clears, tmos, first_clear);
    check("no_timer_lead_ge_100", 32'(lead >= 100), 1);
    check("no_timer_pulses",      tmos,   0);
    check("no_timer_clears",      clears, 0);
`endif
    settle();

    // enable_i drops three cycles into REF_LEAD
    lead = 0; clears = 0; tmos = 0;
    for (int i = 0; i < SYNC + 6; i++) begin
      tick(1'b1, 1'b0, !(i >= SYNC + 3));
      if (ci != CI_HOLD) lead++;
      if (clr) clears++;
      if (tmo) tmos++;
    end
    check("abort_lead_len", lead,   3);
    check("abort_clears",   clears, 0);
    check("abort_tmos",     tmos,   0);
    settle();

    // reset asserted mid-window must clear the output without a clock edge
    for (int i = 0; i < SYNC + 3; i++) tick(1'b1, 1'b0, 1'b1);
    check("mid_window_up", ci, CI_UP);
    do_reset();
    settle();

    // Randomized square waves with random half-periods and enable drops.
    r = 1'b0; f = 1'b0; ref_cnt = 0; fb_cnt = 3; dis_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if (ref_cnt == 0) begin r = ~r; ref_cnt = $urandom_range(1, 24); end
      else ref_cnt--;
      if (fb_cnt == 0) begin f = ~f; fb_cnt = $urandom_range(1, 24); end
      else fb_cnt--;
      if (dis_cnt > 0) dis_cnt--;
      else if ($urandom_range(0, 199) == 0) dis_cnt = $urandom_range(1, 5);
      tick(r, f, dis_cnt == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
